hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage (IF, RF, EX, DM, WB) 64-bit CPU.
- Detects load-use hazards that forwarding cannot cover and inserts one-cycle stalls and bubbles.
- Squashes the wrong-path fetch on a taken branch.
- Freezes the whole pipeline while data memory handshakes a multi-cycle access, with a timeout that latches a fatal error.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before ERROR.
CNT_W, 16, width of saturating statistics counters.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
rf_rn  input  5  Rn field of instruction in RF stage
rf_rm  input  5  Rm/Rt field selected by Reg2Loc in RF stage
rf_uses_rn  input  1  RF instruction reads Rn
rf_uses_rm  input  1  RF instruction reads Rm/Rt
ex_mem_read  input  1  instruction in EX is a load (LDUR)
ex_rd  input  5  destination register of EX instruction
br_taken  input  1  branch resolved taken in RF stage
dm_req  input  1  DM stage issuing read or write this cycle
dm_ready  input  1  data memory completes access this cycle
pc_write_en  output  1  PC may update
ifrf_write_en  output  1  IF/RF pipeline register may load
if_flush  output  1  IF/RF register loads NOP (all-zero flags) instead of fetched word
rfex_write_en  output  1  RF/EX register may load
rfex_bubble  output  1  RF/EX loads zero flags (RegWrite=0, MemWrite=0, no branch)
exdm_write_en  output  1  EX/DM register may load
dmwb_bubble  output  1  DM/WB loads zero flags
br_allow  output  1  branch mux may use br_taken
stall_cycles  output  CNT_W  saturating count of load-use stall cycles
mem_wait_cycles  output  CNT_W  saturating count of MEM_WAIT cycles
flush_count  output  CNT_W  saturating count of branch flushes
error  output  1  sticky memory-timeout flag

Behaviour:
- Reset (async, immediate):
  - State RUN; wait counter 0; all counters 0; error=0.
  - While reset is high: pc_write_en=0, ifrf_write_en=0, rfex_write_en=0, exdm_write_en=0, if_flush=1, rfex_bubble=1, dmwb_bubble=1, br_allow=0.
  - Reset mid-wait or in ERROR returns to RUN the same way.
- load_use = ex_mem_read & (ex_rd != 31) & ((rf_uses_rn & ex_rd==rf_rn) | (rf_uses_rm & ex_rd==rf_rm)). X31 never creates a hazard.
- mem_stall = dm_req & ~dm_ready.
- States: RUN, MEM_WAIT, ERROR.
- RUN, priority mem_stall > load_use > br_taken. All outputs are combinational from state and inputs.
  - mem_stall: every write enable is 0; dmwb_bubble=1; br_allow=0. Next state MEM_WAIT with wait counter=1.
  - load_use: pc_write_en=0, ifrf_write_en=0, rfex_bubble=1, br_allow=0. EX/DM and WB advance. Exactly one stall cycle: the next cycle EX holds the bubble, so the condition self-clears.
  - br_taken and no load_use: if_flush=1, br_allow=1, all enables 1. flush_count increments.
  - Otherwise: all enables 1, bubbles 0, br_allow=1.
- MEM_WAIT:
  - dm_ready=0: freeze as above. Wait counter increments. stall outputs held.
  - When the wait counter reaches MEM_TIMEOUT with dm_ready still 0, next state is ERROR.
  - dm_ready=1: outputs evaluated as in RUN for this cycle (load_use/branch still honoured). Next state RUN; wait counter cleared.
- ERROR: all enables 0, all bubbles and flush 1, error=1, br_allow=0. Leaves only via reset.
- Simultaneous load_use and br_taken: the branch is suppressed (operands are stale). It re-resolves the next cycle.
- Counters:
  - stall_cycles increments on each load_use stall cycle.
  - mem_wait_cycles increments on each frozen cycle.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Latency: zero-cycle combinational decision; one-cycle registered state transition.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MEM_WAIT, ERROR}
  - ZERO_REG = 5'd31
  - flag-field bit positions used by the bubble logic
- One sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). Instantiated three times.

Test Plan:
- Load-use hit: EX=LDUR X2; RF=ADD X3,X2,X4, uses_rn=1. Required: pc_write_en=0, ifrf_write_en=0, rfex_bubble=1 for exactly 1 cycle; stall_cycles=1.
- Zero register: same as above but ex_rd=31, rf_rn=31. Required: no stall; all enables 1.
- Taken branch: br_taken=1, no hazard. Required: if_flush=1 for 1 cycle; flush_count=1. Load-use concurrent with br_taken: required br_allow=0, if_flush=0.
- Memory wait: dm_req=1, dm_ready=0 for 3 cycles, then 1. Required: 3 frozen cycles with all enables 0; release on the dm_ready cycle; mem_wait_cycles=3; state RUN.
- Timeout: MEM_TIMEOUT=4, dm_ready held 0. Required: error=1 after the 4th wait cycle and stays set. Async reset mid-ERROR clears error within the reset-high cycle, before any clock edge.
- Saturation: CNT_W=4, 20 load-use stalls. Required: stall_cycles=15, never wraps.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// hardwired zero register and the per-stage control flag layout.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd31;

  // Control flags carried down the pipeline registers; a bubble is this struct cleared to all zeros.
  typedef struct packed {
    logic branch;
    logic mem_write;
    logic mem_read;
    logic reg_write;
  } stage_flags_t;

  // Writes to X31 are discarded, so a load targeting it never feeds a consumer.
  function automatic logic can_hazard(input logic [4:0] rd);
    return rd != ZERO_REG;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rf_rn;
  logic [4:0]       rf_rm;
  logic             rf_uses_rn;
  logic             rf_uses_rm;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             br_taken;
  // dm_req/dm_ready: an access completes in the cycle both are high; while
  // dm_req (or an access already in progress) sees dm_ready low the pipeline freezes.
  logic             dm_req;
  logic             dm_ready;

  logic             pc_write_en;
  logic             ifrf_write_en;
  logic             if_flush;
  logic             rfex_write_en;
  logic             rfex_bubble;
  logic             exdm_write_en;
  logic             dmwb_bubble;
  logic             br_allow;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] mem_wait_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             error;

  modport master (
    output rf_rn, rf_rm, rf_uses_rn, rf_uses_rm, ex_mem_read, ex_rd,
           br_taken, dm_req, dm_ready,
    input  pc_write_en, ifrf_write_en, if_flush, rfex_write_en, rfex_bubble,
           exdm_write_en, dmwb_bubble, br_allow, stall_cycles, mem_wait_cycles,
           flush_count, error
  );

  modport slave (
    input  rf_rn, rf_rm, rf_uses_rn, rf_uses_rm, ex_mem_read, ex_rd,
           br_taken, dm_req, dm_ready,
    output pc_write_en, ifrf_write_en, if_flush, rfex_write_en, rfex_bubble,
           exdm_write_en, dmwb_bubble, br_allow, stall_cycles, mem_wait_cycles,
           flush_count, error
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/freeze sequencing for the 5-stage pipeline: load-use stalls,
// taken-branch squash, and data-memory wait freeze with a fatal timeout.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic    clk,
  input  logic    reset,
  hazard_if.slave bus,
  output state_t  fsm_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              load_use;
  logic              mem_stall;
  logic              frozen;
  logic              active;
  logic              stall_inc;
  logic              wait_inc;
  logic              flush_inc;

  assign load_use  = bus.ex_mem_read && can_hazard(bus.ex_rd) &&
                     ((bus.rf_uses_rn && (bus.ex_rd == bus.rf_rn)) ||
                      (bus.rf_uses_rm && (bus.ex_rd == bus.rf_rm)));
  assign mem_stall = bus.dm_req && !bus.dm_ready;
  // Once waiting, only dm_ready releases the freeze, whatever dm_req does.
  assign frozen    = ((state == RUN) && mem_stall) ||
                     ((state == MEM_WAIT) && !bus.dm_ready);
  assign active    = !reset && (state != ERROR);
  assign stall_inc = active && !frozen && load_use;
  assign wait_inc  = active && frozen;
  assign flush_inc = active && !frozen && !load_use && bus.br_taken;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.dm_ready) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next = ERROR;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      ERROR:   state_next = ERROR;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    bus.pc_write_en   = 1'b1;
    bus.ifrf_write_en = 1'b1;
    bus.rfex_write_en = 1'b1;
    bus.exdm_write_en = 1'b1;
    bus.if_flush      = 1'b0;
    bus.rfex_bubble   = 1'b0;
    bus.dmwb_bubble   = 1'b0;
    bus.br_allow      = 1'b1;
    bus.error         = 1'b0;
    if (reset || (state == ERROR)) begin
      bus.pc_write_en   = 1'b0;
      bus.ifrf_write_en = 1'b0;
      bus.rfex_write_en = 1'b0;
      bus.exdm_write_en = 1'b0;
      bus.if_flush      = 1'b1;
      bus.rfex_bubble   = 1'b1;
      bus.dmwb_bubble   = 1'b1;
      bus.br_allow      = 1'b0;
      bus.error         = !reset;
    end else if (frozen) begin
      bus.pc_write_en   = 1'b0;
      bus.ifrf_write_en = 1'b0;
      bus.rfex_write_en = 1'b0;
      bus.exdm_write_en = 1'b0;
      bus.dmwb_bubble   = 1'b1;
      bus.br_allow      = 1'b0;
    end else if (load_use) begin
      // Branch operands are stale behind the load, so the branch waits a cycle too.
      bus.pc_write_en   = 1'b0;
      bus.ifrf_write_en = 1'b0;
      bus.rfex_bubble   = 1'b1;
      bus.br_allow      = 1'b0;
    end else if (bus.br_taken) begin
      bus.if_flush = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .count(bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk(clk), .reset(reset), .inc(wait_inc), .count(bus.mem_wait_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_inc), .count(bus.flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios then random
// stimulus, each cycle's expected outputs taken from a behavioural model.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int T  = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rf_rn;
    logic [4:0] rf_rm;
    logic       uses_rn;
    logic       uses_rm;
    logic       ld;
    logic [4:0] ex_rd;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic          pc_write_en;
    logic          ifrf_write_en;
    logic          if_flush;
    logic          rfex_write_en;
    logic          rfex_bubble;
    logic          exdm_write_en;
    logic          dmwb_bubble;
    logic          br_allow;
    logic          error;
    state_t        st;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] mem_wait_cycles;
    logic [CW-1:0] flush_count;
  } outs_t;

  localparam int OW = $bits(outs_t);

  // clock / reset
  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  state_t fsm_state;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CW)) bus ();

  hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fsm_state(fsm_state)
  );

  // reference model: consecutive frozen cycles of the current access, dead after timeout
  int waited  = 0;
  bit dead    = 0;
  int m_stall = 0;
  int m_wait  = 0;
  int m_flush = 0;

  int vectors     = 0;
  int miscompares = 0;

  logic [OW-1:0] exp_q[$];
  string         tag_q[$];

  function automatic int sat(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  function automatic bit is_load_use(input stim_t s);
    if (!s.ld || s.ex_rd == 5'd31) return 1'b0;
    return (s.uses_rn && s.ex_rd == s.rf_rn) || (s.uses_rm && s.ex_rd == s.rf_rm);
  endfunction

  function automatic bit is_frozen(input stim_t s);
    return (waited > 0) ? !s.rdy : (s.req && !s.rdy);
  endfunction

  function automatic outs_t model_out(input stim_t s);
    outs_t o;
    o.stall_cycles    = CW'(m_stall);
    o.mem_wait_cycles = CW'(m_wait);
    o.flush_count     = CW'(m_flush);
    o.error           = 1'b0;
    o.st              = (waited > 0) ? MEM_WAIT : RUN;
    if (s.rst || dead) begin
      {o.pc_write_en, o.ifrf_write_en, o.rfex_write_en, o.exdm_write_en} = 4'b0000;
      {o.if_flush, o.rfex_bubble, o.dmwb_bubble, o.br_allow} = 4'b1110;
      o.error = !s.rst;
      o.st    = s.rst ? RUN : ERROR;
      if (s.rst) begin
        o.stall_cycles    = '0;
        o.mem_wait_cycles = '0;
        o.flush_count     = '0;
      end
    end else if (is_frozen(s)) begin
      {o.pc_write_en, o.ifrf_write_en, o.rfex_write_en, o.exdm_write_en} = 4'b0000;
      {o.if_flush, o.rfex_bubble, o.dmwb_bubble, o.br_allow} = 4'b0010;
    end else if (is_load_use(s)) begin
      {o.pc_write_en, o.ifrf_write_en, o.rfex_write_en, o.exdm_write_en} = 4'b0011;
      {o.if_flush, o.rfex_bubble, o.dmwb_bubble, o.br_allow} = 4'b0100;
    end else begin
      {o.pc_write_en, o.ifrf_write_en, o.rfex_write_en, o.exdm_write_en} = 4'b1111;
      {o.if_flush, o.rfex_bubble, o.dmwb_bubble, o.br_allow} = {s.br, 3'b001};
    end
    return o;
  endfunction

  task automatic model_step(input stim_t s);
    if (s.rst) begin
      waited  = 0;
      dead    = 0;
      m_stall = 0;
      m_wait  = 0;
      m_flush = 0;
    end else if (!dead) begin
      if (is_frozen(s)) begin
        m_wait = sat(m_wait);
        waited++;
        if (waited >= T) dead = 1;
      end else begin
        waited = 0;
        if (is_load_use(s)) m_stall = sat(m_stall);
        else if (s.br)      m_flush = sat(m_flush);
      end
    end
  endtask

  // driver
  task automatic apply(input stim_t s, input string tag);
    @(posedge clk);
    #1;
    reset           = s.rst;
    bus.rf_rn       = s.rf_rn;
    bus.rf_rm       = s.rf_rm;
    bus.rf_uses_rn  = s.uses_rn;
    bus.rf_uses_rm  = s.uses_rm;
    bus.ex_mem_read = s.ld;
    bus.ex_rd       = s.ex_rd;
    bus.br_taken    = s.br;
    bus.dm_req      = s.req;
    bus.dm_ready    = s.rdy;
    exp_q.push_back(model_out(s));
    tag_q.push_back(tag);
    model_step(s);
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    outs_t a;
    outs_t e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.pc_write_en     = bus.pc_write_en;
      a.ifrf_write_en   = bus.ifrf_write_en;
      a.if_flush        = bus.if_flush;
      a.rfex_write_en   = bus.rfex_write_en;
      a.rfex_bubble     = bus.rfex_bubble;
      a.exdm_write_en   = bus.exdm_write_en;
      a.dmwb_bubble     = bus.dmwb_bubble;
      a.br_allow        = bus.br_allow;
      a.error           = bus.error;
      a.st              = fsm_state;
      a.stall_cycles    = bus.stall_cycles;
      a.mem_wait_cycles = bus.mem_wait_cycles;
      a.flush_count     = bus.flush_count;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h required %h (pc ifrf flush rfex_we rfex_bub exdm dmwb br err st stall wait flush)",
                 t, $time, a, e);
      end
    end
  end

  // stimulus
  initial begin
    stim_t s;
    bus.rf_rn       = '0;
    bus.rf_rm       = '0;
    bus.rf_uses_rn  = 1'b0;
    bus.rf_uses_rm  = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = '0;
    bus.br_taken    = 1'b0;
    bus.dm_req      = 1'b0;
    bus.dm_ready    = 1'b0;

    s = '0; s.rst = 1'b1;
    apply(s, "reset");
    apply(s, "reset");
    s = '0;
    apply(s, "idle");

    s = '0; s.ld = 1'b1; s.ex_rd = 5'd2; s.rf_rn = 5'd2; s.rf_rm = 5'd4;
    s.uses_rn = 1'b1; s.uses_rm = 1'b1;
    apply(s, "load_use");
    s.ld = 1'b0;
    apply(s, "load_use_clear");

    s = '0; s.ld = 1'b1; s.ex_rd = 5'd31; s.rf_rn = 5'd31; s.uses_rn = 1'b1;
    apply(s, "zero_reg");
    s = '0; s.ld = 1'b1; s.ex_rd = 5'd7; s.rf_rm = 5'd7; s.uses_rm = 1'b1;
    apply(s, "rm_hit");
    s.ld = 1'b0;
    apply(s, "rm_clear");
    s = '0; s.ld = 1'b1; s.ex_rd = 5'd9; s.rf_rn = 5'd9;
    apply(s, "rn_unused");

    s = '0; s.br = 1'b1;
    apply(s, "branch");
    s = '0;
    apply(s, "branch_after");
    s = '0; s.br = 1'b1; s.ld = 1'b1; s.ex_rd = 5'd5; s.rf_rn = 5'd5; s.uses_rn = 1'b1;
    apply(s, "load_use_branch");
    s.ld = 1'b0;
    apply(s, "branch_reresolve");

    s = '0; s.req = 1'b1;
    repeat (3) apply(s, "mem_wait");
    s.rdy = 1'b1; s.br = 1'b1;
    apply(s, "mem_release");
    s = '0;
    apply(s, "mem_after");

    s = '0; s.req = 1'b1;
    repeat (T) apply(s, "timeout");
    s.rdy = 1'b1;
    repeat (2) apply(s, "error_sticky");
    s = '0; s.rst = 1'b1;
    apply(s, "reset_in_error");
    s = '0;
    apply(s, "after_reset");

    repeat (20) begin
      s = '0; s.ld = 1'b1; s.ex_rd = 5'd3; s.rf_rm = 5'd3; s.uses_rm = 1'b1;
      apply(s, "saturate");
      s.ld = 1'b0;
      apply(s, "saturate_clear");
    end

    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rst     = ($urandom_range(0, 39) == 0);
      s.ld      = 1'($urandom_range(0, 1));
      s.ex_rd   = pick_reg();
      s.rf_rn   = pick_reg();
      s.rf_rm   = pick_reg();
      s.uses_rn = 1'($urandom_range(0, 1));
      s.uses_rm = 1'($urandom_range(0, 1));
      s.br      = ($urandom_range(0, 3) == 0);
      s.req     = ($urandom_range(0, 3) == 0);
      s.rdy     = ($urandom_range(0, 2) != 0);
      apply(s, "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
